// File: rtl/muldiv_arbiter.sv
// muldiv_arbiter: round-robin sharing of one iterative mul/div engine among N_REQ execution units.
// Optional engine watchdog is enabled by defining MULDIV_TIMEOUT_EN.
`ifndef EX_UNITS
`define EX_UNITS 4
`endif

module muldiv_arbiter #(
   parameter int N_REQ          = `EX_UNITS,
   parameter int ROB_W          = 5,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ-1:0]            req_is_div,
   input  logic [N_REQ-1:0][2:0]       req_funct3,
   input  logic [N_REQ-1:0][31:0]      req_a,
   input  logic [N_REQ-1:0][31:0]      req_b,
   input  logic [N_REQ-1:0][ROB_W-1:0] req_rob_id,
   output logic [N_REQ-1:0]            grant,
   output logic                        unit_start,
   output logic                        unit_kill,
   output logic                        unit_is_div,
   output logic [2:0]                  unit_funct3,
   output logic [31:0]                 unit_a,
   output logic [31:0]                 unit_b,
   input  logic                        unit_done,
   input  logic [31:0]                 unit_result,
   output logic                        resp_valid,
   output logic [31:0]                 resp_data,
   output logic [ROB_W-1:0]            resp_rob_id,
   output logic [N_REQ-1:0]            resp_owner,
   output logic                        resp_err,
   output logic                        busy
);
   localparam int PTR_W = $clog2(N_REQ);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             is_div_q, is_div_d;
   logic [2:0]       funct3_q, funct3_d;
   logic [31:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   logic [31:0]      result_q, result_d;
   logic [ROB_W-1:0] rob_q, rob_d;
   logic [N_REQ-1:0] owner_q, owner_d;
   logic             err_q, err_d;

   logic             sel_found_s;
   logic [PTR_W-1:0] sel_idx_s;
   logic [PTR_W-1:0] cand_s;
   logic             take_s;
   logic             timeout_hit_s;
   logic             timeout_s;

`ifdef MULDIV_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = '0;
      if (state_q == WAIT) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout_hit_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_s;
   assign unused_timeout_s = |TIMEOUT_CYCLES;
   assign timeout_hit_s    = 1'b0;
`endif

   // First requester at or above the pointer, wrapping modulo N_REQ.
   always_comb begin
      sel_found_s = 1'b0;
      sel_idx_s   = '0;
      cand_s      = '0;
      for (int j = 0; j < N_REQ; j++) begin
         cand_s = PTR_W'((int'(ptr_q) + j) % N_REQ);
         if (!sel_found_s && req_valid[cand_s]) begin
            sel_found_s = 1'b1;
            sel_idx_s   = cand_s;
         end else begin
            sel_found_s = sel_found_s;
         end
      end
   end

   assign take_s = (state_q == IDLE) && !flush && !rst && sel_found_s;

   always_comb begin
      grant = '0;
      if (take_s) begin
         grant[sel_idx_s] = 1'b1;
      end else begin
         grant = '0;
      end
   end

   // Flush overrides every state transition; ptr is only advanced by a real grant.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      is_div_d  = is_div_q;
      funct3_d  = funct3_q;
      a_d       = a_q;
      b_d       = b_q;
      result_d  = result_q;
      rob_d     = rob_q;
      owner_d   = owner_q;
      err_d     = err_q;
      timeout_s = 1'b0;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (take_s) begin
                  state_d  = ISSUE;
                  ptr_d    = (sel_idx_s == PTR_W'(N_REQ - 1)) ? '0 : sel_idx_s + PTR_W'(1);
                  is_div_d = req_is_div[sel_idx_s];
                  funct3_d = req_funct3[sel_idx_s];
                  a_d      = req_a[sel_idx_s];
                  b_d      = req_b[sel_idx_s];
                  rob_d    = req_rob_id[sel_idx_s];
                  owner_d  = grant;
                  err_d    = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
            ISSUE: begin
               state_d = WAIT;
            end
            WAIT: begin
               if (unit_done) begin
                  result_d = unit_result;
                  state_d  = RESP;
               end else if (timeout_hit_s) begin
                  timeout_s = 1'b1;
                  result_d  = 32'h0000_0000;
                  err_d     = 1'b1;
                  state_d   = RESP;
               end else begin
                  state_d = WAIT;
               end
            end
            RESP: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and latched-operation registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         is_div_q <= 1'b0;
         funct3_q <= 3'd0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         result_q <= 32'd0;
         rob_q    <= '0;
         owner_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         is_div_q <= is_div_d;
         funct3_q <= funct3_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         rob_q    <= rob_d;
         owner_q  <= owner_d;
         err_q    <= err_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign unit_start  = (state_q == ISSUE) && !flush;
   assign unit_kill   = flush ? ((state_q == ISSUE) || (state_q == WAIT)) : timeout_s;
   assign unit_is_div = is_div_q;
   assign unit_funct3 = funct3_q;
   assign unit_a      = a_q;
   assign unit_b      = b_q;
   assign resp_valid  = (state_q == RESP) && !flush;
   assign resp_data   = result_q;
   assign resp_rob_id = rob_q;
   assign resp_owner  = owner_q;
   assign resp_err    = resp_valid && err_q;

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Scoreboard bench for muldiv_arbiter with a behavioural engine; timeout case runs when MULDIV_TIMEOUT_EN is defined.
module tb_muldiv_arbiter;
   logic             clk, rst, flush;
   logic [3:0]       req_valid, req_is_div;
   logic [3:0][2:0]  req_funct3;
   logic [3:0][31:0] req_a, req_b;
   logic [3:0][4:0]  req_rob_id;
   logic [3:0]       grant;
   logic             unit_start, unit_kill, unit_is_div;
   logic [2:0]       unit_funct3;
   logic [31:0]      unit_a, unit_b;
   logic             unit_done;
   logic [31:0]      unit_result;
   logic             resp_valid;
   logic [31:0]      resp_data;
   logic [4:0]       resp_rob_id;
   logic [3:0]       resp_owner;
   logic             resp_err, busy;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rob;
      logic [3:0]  owner;
      logic        err;
   } exp_t;
   exp_t exp_q[$];

   int n_chk  = 0;
   int n_pass = 0;

   int          eng_k, eng_cnt;
   logic        eng_hang, eng_ovr_en, eng_div, eng_start_seen, eng_kill_seen;
   logic [31:0] eng_ovr, eng_a, eng_b;
   logic [3:0]  oh;

   logic [31:0] rr_a [8] = '{32'd3, 32'd5, 32'd9, 32'd11, 32'd13, 32'd2, 32'd8, 32'd6};
   logic [31:0] rr_b [8] = '{32'd4, 32'd6, 32'd2, 32'd7, 32'd3, 32'd21, 32'd8, 32'd9};
   logic [31:0] rr_p [8] = '{32'd12, 32'd30, 32'd18, 32'd77, 32'd39, 32'd42, 32'd64, 32'd54};
   logic [4:0]  rr_r [8] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};

   muldiv_arbiter #(.N_REQ(4), .ROB_W(5), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req_valid(req_valid), .req_is_div(req_is_div), .req_funct3(req_funct3),
      .req_a(req_a), .req_b(req_b), .req_rob_id(req_rob_id),
      .grant(grant), .unit_start(unit_start), .unit_kill(unit_kill),
      .unit_is_div(unit_is_div), .unit_funct3(unit_funct3), .unit_a(unit_a), .unit_b(unit_b),
      .unit_done(unit_done), .unit_result(unit_result),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_rob_id(resp_rob_id),
      .resp_owner(resp_owner), .resp_err(resp_err), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int u, input logic div, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] rob);
      req_valid[u]  = 1'b1;
      req_is_div[u] = div;
      req_funct3[u] = f3;
      req_a[u]      = a;
      req_b[u]      = b;
      req_rob_id[u] = rob;
   endtask

   task automatic push_exp(input logic [31:0] d, input logic [4:0] r, input logic [3:0] o, input logic e);
      exp_t x;
      x.data = d; x.rob = r; x.owner = o; x.err = e;
      exp_q.push_back(x);
   endtask

   task automatic wait_grant(input logic [3:0] exp_g, input string name);
      int n = 0;
      while (grant === 4'b0000 && n < 30) begin cyc(); @(negedge clk); n++; end
      chk(name, 32'(grant), 32'(exp_g));
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy !== 1'b0 && n < 40) begin cyc(); @(negedge clk); n++; end
      chk(name, 32'(busy), 32'd0);
   endtask

   // Engine model: sees start/kill mid-cycle, raises done k cycles after the start cycle.
   initial begin
      unit_done = 1'b0; unit_result = 32'd0; eng_cnt = 0;
      eng_a = 32'd0; eng_b = 32'd0; eng_div = 1'b0;
      forever begin
         @(negedge clk);
         eng_start_seen = unit_start;
         eng_kill_seen  = unit_kill;
         if (unit_start === 1'b1) begin
            eng_a = unit_a; eng_b = unit_b; eng_div = unit_is_div;
         end
         @(posedge clk);
         #1;
         unit_done = 1'b0;
         if (eng_kill_seen === 1'b1) eng_cnt = 0;
         else if (eng_start_seen === 1'b1) eng_cnt = eng_k;
         if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0 && !eng_hang) begin
               unit_done   = 1'b1;
               unit_result = eng_ovr_en ? eng_ovr : (eng_div ? eng_a / eng_b : eng_a * eng_b);
            end
         end
      end
   end

   // Monitor: every response pops and checks the oldest expectation.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (resp_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
               chk("resp_unexpected", 32'(resp_valid), 32'd0);
            end else begin
               x = exp_q.pop_front();
               chk("resp_data", resp_data, x.data);
               chk("resp_rob_id", 32'(resp_rob_id), 32'(x.rob));
               chk("resp_owner", 32'(resp_owner), 32'(x.owner));
               chk("resp_err", 32'(resp_err), 32'(x.err));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; flush = 1'b0;
      req_valid = '0; req_is_div = '0; req_funct3 = '0; req_a = '0; req_b = '0; req_rob_id = '0;
      eng_k = 1; eng_hang = 1'b0; eng_ovr_en = 1'b0; eng_ovr = 32'd0;
      for (int i = 0; i < 4; i++) set_req(i, 1'b0, 3'd0, rr_a[i], rr_b[i], rr_r[i]);

      @(negedge clk);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_start", 32'(unit_start), 32'd0);
      chk("rst_kill", 32'(unit_kill), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_unit_a", unit_a, 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_resp_owner", 32'(resp_owner), 32'd0);
      cyc(); cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_release_grant", 32'(grant), 32'h1);

      // Round robin with all units requesting, two rounds.
      for (int g = 0; g < 8; g++) begin
         oh = 4'b0001 << (g % 4);
         wait_grant(oh, "rr_grant");
         push_exp(rr_p[g], rr_r[g], oh, 1'b0);
         cyc();
         if (g < 4) set_req(g, 1'b0, 3'd0, rr_a[g+4], rr_b[g+4], rr_r[g+4]);
         else req_valid[g % 4] = 1'b0;
         @(negedge clk);
      end
      wait_idle("rr_idle");

      // Single request: unit 2 mul 7*6, engine latency 3.
      cyc(); eng_k = 3; set_req(2, 1'b0, 3'd0, 32'd7, 32'd6, 5'd9);
      @(negedge clk); chk("single_grant", 32'(grant), 32'h4);
      push_exp(32'd42, 5'd9, 4'b0100, 1'b0);
      cyc(); req_valid[2] = 1'b0;
      @(negedge clk);
      chk("single_start", 32'(unit_start), 32'd1);
      chk("single_unit_a", unit_a, 32'd7);
      chk("single_unit_b", unit_b, 32'd6);
      chk("single_is_div", 32'(unit_is_div), 32'd0);
      cyc(); @(negedge clk);
      chk("single_start_pulse", 32'(unit_start), 32'd0);
      chk("single_busy", 32'(busy), 32'd1);
      cyc(); @(negedge clk);
      cyc(); @(negedge clk); chk("single_resp_early", 32'(resp_valid), 32'd0);
      cyc(); @(negedge clk); chk("single_resp_time", 32'(resp_valid), 32'd1);
      cyc(); @(negedge clk); chk("single_idle", 32'(busy), 32'd0);

      // divu 100/7 from unit 1.
      cyc(); eng_k = 2; set_req(1, 1'b1, 3'd5, 32'd100, 32'd7, 5'd10);
      @(negedge clk); chk("div_grant", 32'(grant), 32'h2);
      push_exp(32'd14, 5'd10, 4'b0010, 1'b0);
      cyc(); req_valid[1] = 1'b0;
      @(negedge clk);
      chk("div_funct3", 32'(unit_funct3), 32'd5);
      chk("div_is_div", 32'(unit_is_div), 32'd1);
      wait_idle("div_idle");

      // Flush two cycles after start; unit 1 waits behind unit 3.
      cyc(); eng_k = 10;
      set_req(3, 1'b0, 3'd0, 32'd2, 32'd3, 5'd11);
      set_req(1, 1'b0, 3'd0, 32'd4, 32'd5, 5'd12);
      @(negedge clk); chk("flush_first_grant", 32'(grant), 32'h8);
      cyc(); req_valid[3] = 1'b0;
      @(negedge clk); chk("flush_start", 32'(unit_start), 32'd1);
      cyc(); @(negedge clk);
      cyc(); flush = 1'b1;
      @(negedge clk);
      chk("flush_kill", 32'(unit_kill), 32'd1);
      chk("flush_no_grant", 32'(grant), 32'd0);
      cyc(); flush = 1'b0; eng_k = 2;
      @(negedge clk);
      chk("flush_idle", 32'(busy), 32'd0);
      chk("flush_next_grant", 32'(grant), 32'h2);
      push_exp(32'd20, 5'd12, 4'b0010, 1'b0);
      cyc(); req_valid[1] = 1'b0;
      @(negedge clk); chk("flush_kill_pulse", 32'(unit_kill), 32'd0);
      wait_idle("flush_done_idle");

      // Flush coincident with done carrying 0x1234.
      cyc(); eng_k = 3; eng_ovr_en = 1'b1; eng_ovr = 32'h0000_1234;
      set_req(0, 1'b0, 3'd0, 32'd1, 32'd1, 5'd13);
      @(negedge clk); chk("fd_grant", 32'(grant), 32'h1);
      cyc(); req_valid[0] = 1'b0; @(negedge clk);
      cyc(); @(negedge clk);
      cyc(); @(negedge clk);
      cyc(); flush = 1'b1;
      @(negedge clk);
      chk("fd_done_present", 32'(unit_done), 32'd1);
      chk("fd_kill", 32'(unit_kill), 32'd1);
      chk("fd_no_resp", 32'(resp_valid), 32'd0);
      cyc(); flush = 1'b0;
      @(negedge clk);
      chk("fd_idle", 32'(busy), 32'd0);
      chk("fd_no_resp_after", 32'(resp_valid), 32'd0);
      cyc(); eng_ovr_en = 1'b0; @(negedge clk);

      // Asynchronous reset in WAIT; the engine's done arrives late.
      cyc(); eng_k = 6; set_req(2, 1'b0, 3'd0, 32'd3, 32'd4, 5'd14);
      @(negedge clk); chk("ar_grant", 32'(grant), 32'h4);
      cyc(); req_valid[2] = 1'b0; @(negedge clk);
      cyc(); @(negedge clk);
      cyc(); #2; rst = 1'b1; #1;
      chk("ar_busy", 32'(busy), 32'd0);
      chk("ar_unit_a", unit_a, 32'd0);
      chk("ar_unit_b", unit_b, 32'd0);
      chk("ar_kill", 32'(unit_kill), 32'd0);
      chk("ar_resp_rob", 32'(resp_rob_id), 32'd0);
      @(negedge clk);
      cyc(); rst = 1'b0;
      @(negedge clk); chk("ar_idle", 32'(busy), 32'd0);
      cyc(); @(negedge clk);
      cyc(); @(negedge clk);
      cyc(); @(negedge clk); chk("ar_late_done", 32'(unit_done), 32'd1);
      cyc(); @(negedge clk);
      chk("ar_late_no_resp", 32'(resp_valid), 32'd0);
      chk("ar_late_idle", 32'(busy), 32'd0);
      cyc(); eng_k = 1;
      set_req(1, 1'b0, 3'd0, 32'd6, 32'd7, 5'd20);
      set_req(3, 1'b0, 3'd0, 32'd12, 32'd12, 5'd21);
      @(negedge clk); chk("ar_ptr_grant", 32'(grant), 32'h2);
      push_exp(32'd42, 5'd20, 4'b0010, 1'b0);
      cyc(); req_valid[1] = 1'b0; @(negedge clk);
      wait_grant(4'b1000, "ar_second_grant");
      push_exp(32'd144, 5'd21, 4'b1000, 1'b0);
      cyc(); req_valid[3] = 1'b0; @(negedge clk);
      wait_idle("ar_final_idle");

`ifdef MULDIV_TIMEOUT_EN
      // Engine never completes: kill after 8 WAIT cycles, error response next.
      cyc(); eng_k = 1; eng_hang = 1'b1;
      set_req(0, 1'b0, 3'd0, 32'd9, 32'd9, 5'd22);
      @(negedge clk); chk("to_grant", 32'(grant), 32'h1);
      push_exp(32'd0, 5'd22, 4'b0001, 1'b1);
      cyc(); req_valid[0] = 1'b0;
      @(negedge clk); chk("to_start", 32'(unit_start), 32'd1);
      for (int c = 0; c < 8; c++) begin
         cyc(); @(negedge clk);
         chk("to_kill", 32'(unit_kill), (c == 7) ? 32'd1 : 32'd0);
      end
      cyc(); @(negedge clk);
      chk("to_resp", 32'(resp_valid), 32'd1);
      eng_hang = 1'b0;
      wait_idle("to_idle");
`endif

      cyc(); @(negedge clk);
      cyc(); @(negedge clk);
      chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
